// File: rtl/chunk_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands processed CHUNK bits per clock
// with a registered carry, start/busy/done handshake and signed-overflow flag.
module chunk_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   y,
    output logic             ovf
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   y_q, y_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   ch_sum;
    logic             last;

    // Operand B is stored already inverted for subtract, so RUN only ever adds.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cnt_q == CW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
        ch_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        last   = (cnt_q == CW'(NCH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (cnt_q == CW'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
                    end
                end
                carry_d = ch_sum[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    // Result is captured from the combinational final chunk so y/ovf land on FIN entry.
                    state_d = FIN;
                    cnt_d   = '0;
                    y_d     = {ch_sum[CHUNK], sum_d};
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == FIN);
    assign y    = y_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_adder.sv
// Self-checking bench for chunk_adder: default 8/2 instance plus a 2/1 instance,
// checked against a signed/unsigned arithmetic reference model.
module tb_chunk_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, sub = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, ovf;
    logic [8:0] y;

    logic       start2 = 1'b0, sub2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, ovf2;
    logic [2:0] y2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chunk_adder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .ovf(ovf)
    );

    chunk_adder #(.WIDTH(2), .CHUNK(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .y(y2), .ovf(ovf2)
    );

    // Reference: {ovf, y} from plain integer arithmetic.
    function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] z, input logic s);
        int sx, sz, r, u;
        logic ov;
        sx = $signed(x);
        sz = $signed(z);
        r  = s ? sx - sz : sx + sz;
        ov = (r > 127) || (r < -128);
        u  = s ? int'(x) + 256 - int'(z) : int'(x) + int'(z);
        return {ov, u[8:0]};
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          output logic [8:0] oy, output logic oovf, output int nbusy, output bit got);
        @(negedge clk);
        a = ta; b = tb; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        nbusy = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
        oy = y;
        oovf = ovf;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, ovf, y} !== 12'h0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b y=%h want all 0", busy, done, ovf, y);
        end
        total++;
        if ({busy2, done2, ovf2, y2} !== 6'h0) begin
            bad++;
            $display("FAIL reset_outputs_small: got busy=%b done=%b ovf=%b y=%h want all 0", busy2, done2, ovf2, y2);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_small_exhaustive;
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                int nb;
                bit got;
                logic [2:0] want;
                want = 3'(ia + ib);
                @(negedge clk);
                a2 = 2'(ia); b2 = 2'(ib); sub2 = 1'b0; start2 = 1'b1;
                @(negedge clk);
                start2 = 1'b0;
                a2 = 2'($urandom); b2 = 2'($urandom);
                nb = 0;
                got = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    if (done2) begin
                        got = 1'b1;
                        break;
                    end
                    if (busy2) nb++;
                    @(negedge clk);
                end
                total++;
                if (!got || nb != 2 || y2 !== want) begin
                    bad++;
                    $display("FAIL small_add %0d+%0d: got y=%0d busy_cycles=%0d done=%b want y=%0d busy_cycles=2 done=1",
                             ia, ib, y2, nb, got, want);
                end
            end
        end
    endtask

    task automatic test_directed;
        logic [7:0] ta [4] = '{8'h7F, 8'hFF, 8'h05, 8'h80};
        logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
        logic       ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [8:0] wy [4] = '{9'h080, 9'h100, 9'h0FE, 9'h17F};
        logic       wo [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            logic [8:0] oy;
            logic oo;
            int nb;
            bit got;
            run_op(ta[k], tb[k], ts[k], oy, oo, nb, got);
            total++;
            if (!got || oy !== wy[k] || oo !== wo[k] || nb != 4) begin
                bad++;
                $display("FAIL directed_%0d: got y=%h ovf=%b busy_cycles=%0d done=%b want y=%h ovf=%b busy_cycles=4 done=1",
                         k, oy, oo, nb, got, wy[k], wo[k]);
            end
            repeat (3) @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || y !== wy[k] || ovf !== wo[k]) begin
                bad++;
                $display("FAIL hold_%0d: got done=%b busy=%b y=%h ovf=%b want done=0 busy=0 y=%h ovf=%b",
                         k, done, busy, y, ovf, wy[k], wo[k]);
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 30; k++) begin
            logic [7:0] ta, tb;
            logic ts;
            logic [9:0] w;
            logic [8:0] oy;
            logic oo;
            int nb;
            bit got;
            ta = 8'($urandom); tb = 8'($urandom); ts = 1'($urandom);
            w = ref_op(ta, tb, ts);
            run_op(ta, tb, ts, oy, oo, nb, got);
            total++;
            if (!got || {oo, oy} !== w || nb != 4) begin
                bad++;
                $display("FAIL random_%0d (%h %s %h): got y=%h ovf=%b busy_cycles=%0d want y=%h ovf=%b busy_cycles=4",
                         k, ta, ts ? "-" : "+", tb, oy, oo, nb, w[8:0], w[9]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int ndone;
        logic [8:0] first_y;
        @(negedge clk);
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first_y = '0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                if (ndone == 0) first_y = y;
                ndone++;
            end
            @(negedge clk);
        end
        total++;
        if (ndone != 1 || first_y !== 9'h030) begin
            bad++;
            $display("FAIL ignore_start: got done_pulses=%0d y=%h want done_pulses=1 y=030", ndone, first_y);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] expq [$];
        int last_done, ndone, nover, nint;
        logic [9:0] w;
        last_done = -1;
        ndone = 0;
        nover = 0;
        nint = 0;
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        expq.push_back(ref_op(a, b, sub));
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && done) nover++;
            if (done) begin
                if (last_done >= 0 && (i - last_done) != 5) begin
                    nint++;
                    $display("FAIL b2b_interval: got %0d cycles between done want 5", i - last_done);
                end
                last_done = i;
                ndone++;
                w = expq.pop_front();
                total++;
                if ({ovf, y} !== w) begin
                    bad++;
                    $display("FAIL b2b_result_%0d: got y=%h ovf=%b want y=%h ovf=%b", ndone, y, ovf, w[8:0], w[9]);
                end
                a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
                expq.push_back(ref_op(a, b, sub));
            end
        end
        start = 1'b0;
        total++;
        if (nint != 0 || nover != 0 || ndone < 7) begin
            bad++;
            $display("FAIL b2b_timing: got bad_intervals=%0d busy_with_done=%0d done_pulses=%0d want 0 0 >=7", nint, nover, ndone);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [9:0] w;
        logic [8:0] oy;
        logic oo;
        int nb, nd;
        bit got;
        @(negedge clk);
        a = 8'hC3; b = 8'h5A; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, ovf, y} !== 12'h0) begin
            bad++;
            $display("FAIL reset_mid: got busy=%b done=%b ovf=%b y=%h want all 0", busy, done, ovf, y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        total++;
        if (nd != 0) begin
            bad++;
            $display("FAIL reset_abort: got %0d cycles of busy/done after abort want 0", nd);
        end
        w = ref_op(8'h64, 8'h9C, 1'b1);
        run_op(8'h64, 8'h9C, 1'b1, oy, oo, nb, got);
        total++;
        if (!got || {oo, oy} !== w || nb != 4) begin
            bad++;
            $display("FAIL after_reset_op: got y=%h ovf=%b busy_cycles=%0d want y=%h ovf=%b busy_cycles=4",
                     oy, oo, nb, w[8:0], w[9]);
        end
    endtask

    initial begin
        test_reset();
        test_small_exhaustive();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
